mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 149 ++++++++++++++
 tb/tb_mc_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/writeback sequencing
// with a sticky trap on undecodable instructions.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_is_instr,
  output logic       mem_we,
  output logic [1:0] mem_size,
  output logic       load_unsigned,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       reg_write,
  output logic [2:0] state,
  output logic       illegal
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t     st;
  logic [6:0] op_q;
  logic [2:0] f3_q;

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_OPIMM, OP_OP: is_legal = 1'b1;
      OP_JALR:   is_legal = (f3 == 3'b000);
      OP_LOAD:   is_legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OP_STORE:  is_legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
      OP_BRANCH: is_legal = (f3 != 3'b010) && (f3 != 3'b011);
      default:   is_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= FETCH;
      op_q    <= '0;
      f3_q    <= '0;
      illegal <= 1'b0;
    end else begin
      case (st)
        FETCH:  if (mem_ready) st <= DECODE;
        DECODE: begin
          op_q <= opcode;
          f3_q <= funct3;
          if (is_legal(opcode, funct3)) st <= EXEC;
          else begin
            st      <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          if (op_q == OP_BRANCH)                         st <= FETCH;
          else if (op_q == OP_LOAD || op_q == OP_STORE)  st <= MEM;
          else                                           st <= WB;
        end
        MEM:     if (mem_ready) st <= (op_q == OP_STORE) ? FETCH : WB;
        WB:      st <= FETCH;
        TRAP:    st <= TRAP;
        default: st <= FETCH;
      endcase
    end
  end

  assign state = st;

  always_comb begin
    mem_req       = 1'b0;
    mem_is_instr  = 1'b0;
    mem_we        = 1'b0;
    mem_size      = 2'b00;
    load_unsigned = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 2'b00;
    alu_op        = 2'b00;
    alu_src       = 1'b0;
    reg_write     = 1'b0;
    if (st == DECODE || st == EXEC || st == MEM || st == WB) begin
      case (op_q)
        OP_LUI:             begin alu_op = 2'b00; alu_src = 1'b1; end
        OP_AUIPC, OP_JALR:  begin alu_op = 2'b10; alu_src = 1'b1; end
        OP_OPIMM:           begin alu_op = 2'b11; alu_src = 1'b1; end
        OP_OP:              begin alu_op = 2'b11; alu_src = 1'b0; end
        OP_LOAD, OP_STORE:  begin alu_op = 2'b10; alu_src = 1'b1; end
        OP_BRANCH:          begin alu_op = 2'b01; alu_src = 1'b0; end
        default:            begin alu_op = 2'b00; alu_src = 1'b0; end
      endcase
    end
    case (st)
      FETCH: begin
        mem_req      = 1'b1;
        mem_is_instr = 1'b1;
        mem_size     = 2'b10;
        ir_write     = mem_ready;
      end
      EXEC: if (op_q == OP_BRANCH) begin
        pc_write = 1'b1;
        pc_sel   = branch_taken ? 2'b01 : 2'b00;
      end
      MEM: begin
        mem_req       = 1'b1;
        mem_we        = (op_q == OP_STORE);
        mem_size      = f3_q[1:0];
        load_unsigned = f3_q[2];
        pc_write      = (op_q == OP_STORE) && mem_ready;
      end
      WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        pc_sel    = (op_q == OP_JAL) ? 2'b01 : (op_q == OP_JALR) ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
    // Reset overrides everything so a pending memory handshake cannot leak a strobe.
    if (rst) begin
      mem_req       = 1'b1;
      mem_is_instr  = 1'b1;
      mem_we        = 1'b0;
      mem_size      = 2'b10;
      load_unsigned = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_sel        = 2'b00;
      alu_op        = 2'b00;
      alu_src       = 1'b0;
      reg_write     = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed vector bench for mc_ctrl: per-cycle expected outputs for each
// instruction class, trap hold, and reset during a memory wait.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst, branch_taken, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic mem_req, mem_is_instr, mem_we, load_unsigned, ir_write, pc_write;
  logic alu_src, reg_write, illegal;
  logic [1:0] mem_size, pc_sel, alu_op;
  logic [2:0] state;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_is_instr(mem_is_instr), .mem_we(mem_we),
    .mem_size(mem_size), .load_unsigned(load_unsigned), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .alu_op(alu_op), .alu_src(alu_src),
    .reg_write(reg_write), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        tk;
    logic        rdy;
    logic [17:0] exp;
    logic [17:0] msk;
    string       nm;
  } vec_t;

  // {state, mem_req, mem_is_instr, mem_we, mem_size, load_unsigned, ir_write,
  //  pc_write, pc_sel, alu_op, alu_src, reg_write, illegal}
  localparam logic [17:0] ALL   = 18'h3FFFF;
  localparam logic [17:0] NOALU = 18'h3FFE3;  // alu fields ignored in DECODE
  localparam logic [17:0] RSTM  = 18'h07FFE;  // state/illegal not yet reset before the edge

  localparam logic [6:0] ADD = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BAD = 7'b1111111;

  vec_t vq[$];
  int total = 0;
  int bad = 0;
  bit done = 1'b0;

  function automatic logic [17:0] mk(input logic [2:0] st, input logic req, input logic isi,
      input logic we, input logic [1:0] sz, input logic lu, input logic ir, input logic pcw,
      input logic [1:0] pcs, input logic [1:0] aop, input logic asrc, input logic rw,
      input logic ill);
    mk = {st, req, isi, we, sz, lu, ir, pcw, pcs, aop, asrc, rw, ill};
  endfunction

  function automatic void add(input logic r, input logic [6:0] op, input logic [2:0] f3,
      input logic tk, input logic rdy, input logic [17:0] e, input logic [17:0] m,
      input string nm);
    vec_t x;
    x.rst = r; x.op = op; x.f3 = f3; x.tk = tk; x.rdy = rdy;
    x.exp = e; x.msk = m; x.nm = nm;
    vq.push_back(x);
  endfunction

  // Fetch with ready, then decode; common prefix of every instruction.
  function automatic void fd(input logic [6:0] op, input logic [2:0] f3, input string nm);
    add(0, op, f3, 0, 1, mk(0,1,1,0,2,0,1,0,0,0,0,0,0), ALL,   {nm, "_fetch"});
    add(0, op, f3, 0, 1, mk(1,0,0,0,0,0,0,0,0,0,0,0,0), NOALU, {nm, "_decode"});
  endfunction

  logic [17:0] act;
  logic        req_pend;

  initial begin
    #20000;
    if (!done) begin
      bad++;
      $display("FAIL timeout: vector replay did not complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; branch_taken = 1'b0; mem_ready = 1'b0;

    add(1, 0, 0, 0, 1, mk(0,1,1,0,2,0,0,0,0,0,0,0,0), ALL, "rst_hold");
    add(0, 0, 0, 0, 0, mk(0,1,1,0,2,0,0,0,0,0,0,0,0), ALL, "rst_after");
    // ADD
    fd(ADD, 3'b000, "add");
    add(0, ADD, 0, 0, 1, mk(2,0,0,0,0,0,0,0,0,3,0,0,0), ALL, "add_exec");
    add(0, ADD, 0, 0, 1, mk(4,0,0,0,0,0,0,1,0,3,0,1,0), ALL, "add_wb");
    // LHU with one fetch wait and two memory waits
    add(0, LD, 3'b101, 0, 0, mk(0,1,1,0,2,0,0,0,0,0,0,0,0), ALL, "lhu_fwait");
    fd(LD, 3'b101, "lhu");
    add(0, LD, 3'b101, 0, 1, mk(2,0,0,0,0,0,0,0,0,2,1,0,0), ALL, "lhu_exec");
    add(0, LD, 3'b101, 0, 0, mk(3,1,0,0,1,1,0,0,0,2,1,0,0), ALL, "lhu_mwait1");
    add(0, LD, 3'b101, 0, 0, mk(3,1,0,0,1,1,0,0,0,2,1,0,0), ALL, "lhu_mwait2");
    add(0, LD, 3'b101, 0, 1, mk(3,1,0,0,1,1,0,0,0,2,1,0,0), ALL, "lhu_mdone");
    add(0, LD, 3'b101, 0, 1, mk(4,0,0,0,0,0,0,1,0,2,1,1,0), ALL, "lhu_wb");
    // BEQ taken, then not taken
    fd(BR, 3'b000, "beq_t");
    add(0, BR, 0, 1, 1, mk(2,0,0,0,0,0,0,1,1,1,0,0,0), ALL, "beq_t_exec");
    fd(BR, 3'b000, "beq_n");
    add(0, BR, 0, 0, 1, mk(2,0,0,0,0,0,0,1,0,1,0,0,0), ALL, "beq_n_exec");
    // SB
    fd(ST, 3'b000, "sb");
    add(0, ST, 0, 0, 1, mk(2,0,0,0,0,0,0,0,0,2,1,0,0), ALL, "sb_exec");
    add(0, ST, 0, 0, 1, mk(3,1,0,1,0,0,0,1,0,2,1,0,0), ALL, "sb_mem");
    // JAL / JALR
    fd(JAL, 3'b000, "jal");
    add(0, JAL, 0, 0, 1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0), ALL, "jal_exec");
    add(0, JAL, 0, 0, 1, mk(4,0,0,0,0,0,0,1,1,0,0,1,0), ALL, "jal_wb");
    fd(JALR, 3'b000, "jalr");
    add(0, JALR, 0, 0, 1, mk(2,0,0,0,0,0,0,0,0,2,1,0,0), ALL, "jalr_exec");
    add(0, JALR, 0, 0, 1, mk(4,0,0,0,0,0,0,1,2,2,1,1,0), ALL, "jalr_wb");

    // Illegal opcode: trap holds regardless of mem_ready until reset
    fd(BAD, 3'b000, "bad");
    for (int i = 0; i < 10; i++)
      add(0, BAD, 0, 0, 1, mk(5,0,0,0,0,0,0,0,0,0,0,0,1), ALL, "trap_hold");
    add(1, BAD, 0, 0, 1, mk(0,1,1,0,2,0,0,0,0,0,0,0,0), RSTM, "trap_rst");
    add(0, 0, 0, 0, 0, mk(0,1,1,0,2,0,0,0,0,0,0,0,0), ALL, "trap_cleared");
    // LOAD with reserved funct3 also traps
    fd(LD, 3'b011, "ld011");
    add(0, LD, 3'b011, 0, 1, mk(5,0,0,0,0,0,0,0,0,0,0,0,1), ALL, "ld011_trap");
    add(1, LD, 3'b011, 0, 1, mk(0,1,1,0,2,0,0,0,0,0,0,0,0), RSTM, "ld011_rst");
    add(0, 0, 0, 0, 0, mk(0,1,1,0,2,0,0,0,0,0,0,0,0), ALL, "ld011_cleared");
    // SW: reset in the middle of the memory wait
    fd(ST, 3'b010, "sw");
    add(0, ST, 3'b010, 0, 1, mk(2,0,0,0,0,0,0,0,0,2,1,0,0), ALL, "sw_exec");
    add(0, ST, 3'b010, 0, 0, mk(3,1,0,1,2,0,0,0,0,2,1,0,0), ALL, "sw_mwait");
    add(1, ST, 3'b010, 0, 1, mk(0,1,1,0,2,0,0,0,0,0,0,0,0), RSTM, "sw_rst_mid");
    add(0, ST, 3'b010, 0, 0, mk(0,1,1,0,2,0,0,0,0,0,0,0,0), ALL, "sw_after_rst");

    @(negedge clk);
    #1;
    total++;
    if (state !== 3'd0 || illegal !== 1'b0 || mem_req !== 1'b1 || mem_is_instr !== 1'b1 ||
        mem_we !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: state=%0d illegal=%b mem_req=%b mem_is_instr=%b mem_we=%b ir=%b pcw=%b rw=%b",
               state, illegal, mem_req, mem_is_instr, mem_we, ir_write, pc_write, reg_write);
    end

    req_pend = 1'b0;
    foreach (vq[i]) begin
      rst = vq[i].rst; opcode = vq[i].op; funct3 = vq[i].f3;
      branch_taken = vq[i].tk; mem_ready = vq[i].rdy;
      #1;
      act = {state, mem_req, mem_is_instr, mem_we, mem_size, load_unsigned, ir_write,
             pc_write, pc_sel, alu_op, alu_src, reg_write, illegal};
      total++;
      if ((act & vq[i].msk) !== (vq[i].exp & vq[i].msk)) begin
        bad++;
        $display("FAIL %s (row %0d): got %b expected %b mask %b",
                 vq[i].nm, i, act, vq[i].exp, vq[i].msk);
      end
      if (ir_write === 1'b1 && (pc_write === 1'b1 || reg_write === 1'b1)) begin
        bad++;
        $display("FAIL %s (row %0d): ir_write overlaps pc_write/reg_write", vq[i].nm, i);
      end
      if (req_pend && !rst && mem_req !== 1'b1) begin
        bad++;
        $display("FAIL %s (row %0d): mem_req dropped before mem_ready", vq[i].nm, i);
      end
      req_pend = (mem_req === 1'b1) && (mem_ready !== 1'b1) && !rst;
      @(negedge clk);
    end

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
